tx_packet_arbiter: RTL and testbench
====================================

# tx_packet_arbiter

Packet-level arbiter sharing the single UART transmitter among the three packet sources of the readout: event waveform (0xFFFF), histogram (0xFFFE) and scaler (0xFFFD) packet generators. It replaces ORing `transmit`/`tx_byte` and cross-wiring `tx_busy`. It grants the UART to one source for a whole packet and paces bytes against the UART `is_transmitting` flag. It also recovers from a stalled source or a UART that never reports busy.

## Interface
- `PRIORITY_MODE`, default 1: 0 = fixed priority (source 0 > 1 > 2); 1 = round-robin.
- `TIMEOUT_CYCLES`, default 4095: maximum wait in WAIT_BYTE for the granted source's next byte; range 1..65535.
- `BUSY_RISE_MAX`, default 4: maximum cycles after `transmit_o` for `is_transmitting_i` to rise.

- `CLK` in 1: system clock (PLL output).
- `RST_i` in 1: synchronous reset, active-high.
- `req_i` in 3: per-source packet request, level.
- `byte_valid_i` in 3: per-source byte-offered strobe.
- `last_i` in 3: qualifies `byte_valid_i`; the byte is the final byte of the packet.
- `byte_i` in 24: source n's byte on bits [8n+7:8n].
- `grant_o` out 3: one-hot or zero; the owner of the UART.
- `byte_ready_o` out 3: the arbiter will accept a byte from this source this cycle.
- `transmit_o` out 1: one-cycle start pulse to the UART.
- `tx_byte_o` out 8: byte to the UART, stable from the `transmit_o` cycle until the next byte is latched.
- `is_transmitting_i` in 1: UART busy flag.
- `busy_o` out 1: high when state ≠ IDLE.
- `timeout_o` out 1: one-cycle pulse when a packet is aborted by timeout.
- `lost_busy_o` out 1: one-cycle pulse when the UART busy flag did not rise within `BUSY_RISE_MAX`.

## Operation
- States: IDLE, WAIT_BYTE, START, BUSY_RISE, BUSY_FALL.
- **IDLE**
  - If `req_i` ≠ 0, pick a winner, register it into `grant_o`, clear the timeout counter, go to WAIT_BYTE.
  - Fixed mode: lowest index wins.
  - Round-robin mode: search starts at `last_grant + 1` (mod 3).
- **WAIT_BYTE**
  - `byte_ready_o[g]` = 1 combinationally, where g is the granted index.
  - On `byte_valid_i[g]`: latch `byte_i[g]` into `tx_byte_o`, latch `last_i[g]`, go to START.
  - Otherwise increment the timeout counter. At `TIMEOUT_CYCLES`: pulse `timeout_o`, set `last_grant` = g, clear `grant_o`, go to IDLE.
- **START**: `transmit_o` = 1 for exactly this cycle; go to BUSY_RISE with the rise counter cleared.
- **BUSY_RISE**
  - If `is_transmitting_i` = 1, go to BUSY_FALL.
  - Otherwise increment the rise counter. At `BUSY_RISE_MAX`: pulse `lost_busy_o` and treat the byte as sent, i.e. take the BUSY_FALL exit immediately.
- **BUSY_FALL**
  - Wait for `is_transmitting_i` = 0.
  - If the latched last flag is set: clear `grant_o`, set `last_grant` = g, go to IDLE.
  - Otherwise clear the timeout counter and go to WAIT_BYTE.
- `byte_valid_i` from non-granted sources is ignored. `byte_ready_o` is 0 for every source outside WAIT_BYTE.
- `req_i[g]` dropping mid-packet is ignored; the packet ends only on last byte or timeout.
- A new `req_i` arriving while another source is granted is held by the source until IDLE.

## Timing
- Reset values:
  - `grant_o` = 0, `byte_ready_o` = 0, `transmit_o` = 0, `tx_byte_o` = 0.
  - `busy_o` = 0, `timeout_o` = 0, `lost_busy_o` = 0.
  - `last_grant` = 2, so source 0 wins first in round-robin mode.
  - State IDLE; all counters 0.
- Reset mid-packet aborts without a pulse on `timeout_o`; any UART transfer in progress is not tracked.
- Arbitration latency: `req_i` sampled high in IDLE → `grant_o` and `byte_ready_o` high on the next cycle.
- Byte acceptance:
  - `byte_valid_i` and `byte_ready_o` high on cycle t → `transmit_o` high on t+1 with `tx_byte_o` valid.
  - The earliest next `byte_ready_o` is 1 cycle after `is_transmitting_i` is sampled low.
- Packet gap: at least one IDLE cycle between packets. The grant can never pass between sources without an intervening IDLE cycle.
- Round-robin fairness: with all three requesting continuously, grants rotate 0, 1, 2, 0…
- Counters: timeout counter 16 bit, saturating compare against `TIMEOUT_CYCLES`; rise counter 3 bit.
- Simultaneous `byte_valid_i[g]` and timeout expiry in the same cycle: the byte wins and no timeout occurs.

## Structure
- Shared package `grbalpha_tx_pkg`:
  - state enum;
  - source indices `SRC_EVENT` = 0, `SRC_HIST` = 1, `SRC_SCL` = 2;
  - packet header constants 16'hFFFF, 16'hFFFE, 16'hFFFD.
- One sub-module `rr_pick3`: combinational 3-way picker with inputs `req[2:0]`, `last[1:0]`, `mode`; output one-hot `win[2:0]`. The rest of the block is a single FSM.

## Test plan
- Single packet: source 1 requests and sends 0xFE, 0xFF, 0x12 (last) against a UART model with busy = 10 cycles after `transmit_o` → three `transmit_o` pulses with exactly those bytes, `grant_o` returns to 0.
- Contention, round-robin: `req_i` = 3'b111 held, each source sends 4-byte packets → grant order 0, 1, 2, 0, 1, 2, with one IDLE cycle between grants.
- Fixed priority: `PRIORITY_MODE` = 0, `req_i` = 3'b110 then 3'b111 at the first IDLE → grants 1 then 0; source 2 is served only after source 0 drops its request.
- Stalled source: `TIMEOUT_CYCLES` = 20, source 2 granted but never asserts `byte_valid_i` → `timeout_o` pulses 20 cycles after the grant, then source 0 (pending) is granted.
- Dead UART: `is_transmitting_i` held 0 → `lost_busy_o` pulses 4 cycles after each `transmit_o`, and the packet still completes.
- Reset mid-packet: assert `RST_i` during BUSY_FALL → next cycle all outputs 0, state IDLE, and the first grant after release goes to source 0.

Source files
------------

// File: rtl/grbalpha_tx_pkg.sv
// Shared types and constants for the readout UART transmit path.
package grbalpha_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitByte,
    StStart,
    StBusyRise,
    StBusyFall
  } tx_state_e;

  localparam int unsigned SRC_EVENT = 0;
  localparam int unsigned SRC_HIST  = 1;
  localparam int unsigned SRC_SCL   = 2;

  localparam logic [15:0] HDR_EVENT = 16'hFFFF;
  localparam logic [15:0] HDR_HIST  = 16'hFFFE;
  localparam logic [15:0] HDR_SCL   = 16'hFFFD;

  // Grant vectors are one-hot or zero; zero maps to index 0.
  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[2]) begin
      idx = 2'(SRC_SCL);
    end else if (oh[1]) begin
      idx = 2'(SRC_HIST);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way picker: fixed priority (mode 0) or round-robin from last+1 (mode 1).
module rr_pick3
  import grbalpha_tx_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  input  logic       mode,
  output logic [2:0] win
);

  logic       found;
  logic [1:0] k;
  logic [2:0] s;

  always_comb begin
    win   = '0;
    found = 1'b0;
    k     = 2'd0;
    s     = 3'd0;
    for (int i = 0; i < 3; i++) begin
      if (mode) begin
        s = 3'(last) + 3'(i) + 3'd1;
        k = (s >= 3'd3) ? 2'(s - 3'd3) : 2'(s);
      end else begin
        k = 2'(i);
      end
      if (!found && (k != 2'd3) && req[k]) begin
        win[k] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_packet_arbiter.sv
// Packet-level arbiter granting the single UART transmitter to one of three packet sources,
// pacing bytes against the UART busy flag and recovering from stalled sources or a dead UART.
module tx_packet_arbiter
  import grbalpha_tx_pkg::*;
#(
  parameter int unsigned PRIORITY_MODE  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 4095,
  parameter int unsigned BUSY_RISE_MAX  = 4
) (
  input  logic        CLK,
  input  logic        RST_i,
  input  logic [2:0]  req_i,
  input  logic [2:0]  byte_valid_i,
  input  logic [2:0]  last_i,
  input  logic [23:0] byte_i,
  output logic [2:0]  grant_o,
  output logic [2:0]  byte_ready_o,
  output logic        transmit_o,
  output logic [7:0]  tx_byte_o,
  input  logic        is_transmitting_i,
  output logic        busy_o,
  output logic        timeout_o,
  output logic        lost_busy_o
);

  localparam logic [16:0] TmoLimit  = 17'(TIMEOUT_CYCLES);
  localparam logic [3:0]  RiseLimit = 4'(BUSY_RISE_MAX);
  localparam logic        PrioRr    = (PRIORITY_MODE != 0);

  tx_state_e   state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [15:0] tmo_q, tmo_d;
  logic [2:0]  rise_q, rise_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        last_q, last_d;

  logic [2:0]  win;
  logic [1:0]  g_idx;
  logic        sel_valid, sel_last, byte_done;
  logic [7:0]  sel_byte;
  logic [16:0] tmo_inc;
  logic [3:0]  rise_inc;

  rr_pick3 u_pick (
    .req  (req_i),
    .last (last_grant_q),
    .mode (PrioRr),
    .win  (win)
  );

  assign g_idx     = onehot_to_idx(grant_q);
  assign sel_valid = |(byte_valid_i & grant_q);
  assign sel_last  = |(last_i & grant_q);
  assign sel_byte  = ({8{grant_q[0]}} & byte_i[7:0])
                   | ({8{grant_q[1]}} & byte_i[15:8])
                   | ({8{grant_q[2]}} & byte_i[23:16]);
  assign tmo_inc   = {1'b0, tmo_q} + 17'd1;
  assign rise_inc  = {1'b0, rise_q} + 4'd1;

  assign grant_o      = grant_q;
  assign tx_byte_o    = tx_byte_q;
  assign busy_o       = (state_q != StIdle);
  assign byte_ready_o = (state_q == StWaitByte) ? grant_q : 3'b000;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tmo_d        = tmo_q;
    rise_d       = rise_q;
    tx_byte_d    = tx_byte_q;
    last_d       = last_q;
    transmit_o   = 1'b0;
    timeout_o    = 1'b0;
    lost_busy_o  = 1'b0;
    byte_done    = 1'b0;

    case (state_q)
      StIdle: begin
        if (req_i != 3'b000) begin
          grant_d = win;
          tmo_d   = '0;
          state_d = StWaitByte;
        end
      end
      StWaitByte: begin
        // A byte offered on the expiry cycle takes precedence over the abort.
        if (sel_valid) begin
          tx_byte_d = sel_byte;
          last_d    = sel_last;
          state_d   = StStart;
        end else if (tmo_inc >= TmoLimit) begin
          timeout_o    = 1'b1;
          last_grant_d = g_idx;
          grant_d      = '0;
          state_d      = StIdle;
        end else begin
          tmo_d = tmo_inc[15:0];
        end
      end
      StStart: begin
        transmit_o = 1'b1;
        rise_d     = '0;
        state_d    = StBusyRise;
      end
      StBusyRise: begin
        if (is_transmitting_i) begin
          state_d = StBusyFall;
        end else if (rise_inc >= RiseLimit) begin
          lost_busy_o = 1'b1;
          byte_done   = 1'b1;
        end else begin
          rise_d = rise_inc[2:0];
        end
      end
      StBusyFall: begin
        if (!is_transmitting_i) begin
          byte_done = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (byte_done) begin
      if (last_q) begin
        grant_d      = '0;
        last_grant_d = g_idx;
        state_d      = StIdle;
      end else begin
        tmo_d   = '0;
        state_d = StWaitByte;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_i) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= 2'(SRC_SCL);
      tmo_q        <= '0;
      rise_q       <= '0;
      tx_byte_q    <= '0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tmo_q        <= tmo_d;
      rise_q       <= rise_d;
      tx_byte_q    <= tx_byte_d;
      last_q       <= last_d;
    end
  end

endmodule

// File: tb/tb_tx_packet_arbiter.sv
// Scoreboard bench: a round-robin instance and a fixed-priority instance, each with source
// models and a UART model; offered bytes and expected grants are queued and checked on output.
module tb_tx_packet_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [2];
  logic [2:0]  req        [2];
  logic [2:0]  byte_valid [2];
  logic [2:0]  last       [2];
  logic [23:0] byte_in    [2];
  logic        is_tx      [2];
  logic [2:0]  grant      [2];
  logic [2:0]  ready      [2];
  logic        transmit   [2];
  logic [7:0]  tx_byte    [2];
  logic        busy       [2];
  logic        tmo        [2];
  logic        lost       [2];

  logic [8:0]  src_q [6][$];
  logic [7:0]  exp_b [2][$];
  logic [2:0]  exp_g [2][$];

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   tx_cyc [2];
  int   grant_cyc [2];
  int   tmo_cyc [2];
  int   tmo_cnt [2];
  int   lost_cnt [2];
  int   ucnt [2];
  logic dead [2];
  logic pend [2];
  logic [2:0] prev_g [2];

  tx_packet_arbiter #(
    .PRIORITY_MODE  (1),
    .TIMEOUT_CYCLES (20),
    .BUSY_RISE_MAX  (4)
  ) dut_rr (
    .CLK               (clk),
    .RST_i             (rst[0]),
    .req_i             (req[0]),
    .byte_valid_i      (byte_valid[0]),
    .last_i            (last[0]),
    .byte_i            (byte_in[0]),
    .grant_o           (grant[0]),
    .byte_ready_o      (ready[0]),
    .transmit_o        (transmit[0]),
    .tx_byte_o         (tx_byte[0]),
    .is_transmitting_i (is_tx[0]),
    .busy_o            (busy[0]),
    .timeout_o         (tmo[0]),
    .lost_busy_o       (lost[0])
  );

  tx_packet_arbiter #(
    .PRIORITY_MODE  (0),
    .TIMEOUT_CYCLES (20),
    .BUSY_RISE_MAX  (4)
  ) dut_fx (
    .CLK               (clk),
    .RST_i             (rst[1]),
    .req_i             (req[1]),
    .byte_valid_i      (byte_valid[1]),
    .last_i            (last[1]),
    .byte_i            (byte_in[1]),
    .grant_o           (grant[1]),
    .byte_ready_o      (ready[1]),
    .transmit_o        (transmit[1]),
    .tx_byte_o         (tx_byte[1]),
    .is_transmitting_i (is_tx[1]),
    .busy_o            (busy[1]),
    .timeout_o         (tmo[1]),
    .lost_busy_o       (lost[1])
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  task automatic load_byte(input int d, input int n, input logic [7:0] b, input logic lst);
    src_q[d*3+n].push_back({lst, b});
    req[d][n] = 1'b1;
  endtask

  task automatic load_pkt(input int d, input int n, input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) load_byte(d, n, base + 8'(i), (i == len - 1));
  endtask

  function automatic bit quiet(input int d);
    bit q;
    q = (grant[d] == 3'b000) && !busy[d] && (exp_b[d].size() == 0) &&
        (exp_g[d].size() == 0) && (byte_valid[d] == 3'b000);
    for (int n = 0; n < 3; n++) if (src_q[d*3+n].size() != 0) q = 1'b0;
    return q;
  endfunction

  task automatic wait_done(input int d, input int max);
    int n;
    n = 0;
    while (!quiet(d) && n < max) begin
      @(negedge clk);
      n++;
    end
    check("wait_done", d, 32'(quiet(d)), 1);
  endtask

  task automatic check_all_zero(input int d);
    check("zero_grant", d, grant[d], 0);
    check("zero_ready", d, ready[d], 0);
    check("zero_transmit", d, transmit[d], 0);
    check("zero_tx_byte", d, tx_byte[d], 0);
    check("zero_busy", d, busy[d], 0);
    check("zero_timeout", d, tmo[d], 0);
    check("zero_lost_busy", d, lost[d], 0);
  endtask

  // Monitors, UART model and source models, all evaluated away from the active edge.
  always @(negedge clk) begin
    int k;
    logic [8:0] e;
    for (int d = 0; d < 2; d++) begin
      if (pend[d]) check("accept_to_transmit", d, transmit[d], 1);
      if (transmit[d]) begin
        tx_cyc[d] = cyc;
        check("tx_expected", d, 32'(exp_b[d].size() != 0), 1);
        if (exp_b[d].size() != 0) check("tx_byte", d, tx_byte[d], exp_b[d].pop_front());
      end
      if (lost[d]) begin
        lost_cnt[d]++;
        check("lost_busy_delay", d, cyc - tx_cyc[d], 4);
      end
      if (tmo[d]) begin
        tmo_cnt[d]++;
        tmo_cyc[d] = cyc;
      end
      if (grant[d] != prev_g[d]) begin
        if (prev_g[d] == 3'b000) begin
          grant_cyc[d] = cyc;
          check("grant_expected", d, 32'(exp_g[d].size() != 0), 1);
          if (exp_g[d].size() != 0) check("grant_order", d, grant[d], exp_g[d].pop_front());
        end else if (grant[d] == 3'b000) begin
          check("idle_after_packet", d, busy[d], 0);
        end else begin
          check("handover_without_idle", d, grant[d], 0);
        end
        prev_g[d] = grant[d];
      end

      if (transmit[d] && !dead[d]) begin
        ucnt[d] = 10;
      end else if (ucnt[d] > 0) begin
        is_tx[d] = 1'b1;
        ucnt[d]--;
      end else begin
        is_tx[d] = 1'b0;
      end

      for (int n = 0; n < 3; n++) begin
        k = d * 3 + n;
        if (byte_valid[d][n]) begin
          byte_valid[d][n] = 1'b0;
          if (src_q[k].size() != 0) e = src_q[k].pop_front();
          if (src_q[k].size() == 0) req[d][n] = 1'b0;
        end else if (ready[d][n] && src_q[k].size() != 0) begin
          byte_valid[d][n]     = 1'b1;
          byte_in[d][8*n +: 8] = src_q[k][0][7:0];
          last[d][n]           = src_q[k][0][8];
          exp_b[d].push_back(src_q[k][0][7:0]);
        end
      end
      pend[d] = |(byte_valid[d] & ready[d]);
    end
  end

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = '0; byte_valid[d] = '0; last[d] = '0; byte_in[d] = '0;
      is_tx[d] = 1'b0; dead[d] = 1'b0; pend[d] = 1'b0; prev_g[d] = '0; ucnt[d] = 0;
      tmo_cnt[d] = 0; lost_cnt[d] = 0; tx_cyc[d] = 0; grant_cyc[d] = 0; tmo_cyc[d] = 0;
    end
    repeat (3) @(negedge clk);
    check_all_zero(0);
    check_all_zero(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Round-robin contention: two 4-byte packets per source, all requesting.
    for (int i = 0; i < 2; i++) begin
      exp_g[0].push_back(3'b001);
      exp_g[0].push_back(3'b010);
      exp_g[0].push_back(3'b100);
    end
    for (int pk = 0; pk < 2; pk++)
      for (int s = 0; s < 3; s++) load_pkt(0, s, 4, 8'(8'h10 * s + 8'h08 * pk + 8'h01));
    wait_done(0, 3000);

    // Single packet from source 1.
    exp_g[0].push_back(3'b010);
    load_byte(0, 1, 8'hFE, 1'b0);
    load_byte(0, 1, 8'hFF, 1'b0);
    load_byte(0, 1, 8'h12, 1'b1);
    wait_done(0, 500);

    // Stalled source 2, source 0 pending behind it.
    exp_g[0].push_back(3'b100);
    req[0][2] = 1'b1;
    n = 0;
    while (grant[0] != 3'b100 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("grant_stalled_src", 0, grant[0], 3'b100);
    exp_g[0].push_back(3'b001);
    load_pkt(0, 0, 2, 8'hA0);
    n = 0;
    while (tmo_cnt[0] == 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    req[0][2] = 1'b0;
    check("timeout_seen", 0, tmo_cnt[0], 1);
    // Abort lands on the 20th waiting cycle; the first waiting cycle shows the grant.
    check("timeout_delay", 0, tmo_cyc[0] - grant_cyc[0], 19);
    wait_done(0, 500);

    // Dead UART: busy never rises, packet must still complete.
    dead[0] = 1'b1;
    exp_g[0].push_back(3'b001);
    load_pkt(0, 0, 3, 8'h55);
    wait_done(0, 500);
    check("lost_busy_count", 0, lost_cnt[0], 3);
    dead[0] = 1'b0;

    // Reset while waiting for the UART to go idle.
    exp_g[0].push_back(3'b100);
    load_pkt(0, 2, 3, 8'hC3);
    n = 0;
    while (!transmit[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reset_test_transmit", 0, transmit[0], 1);
    repeat (3) @(negedge clk);
    check("reset_test_in_busy_fall", 0, 32'(busy[0] && is_tx[0]), 1);
    rst[0] = 1'b1;
    @(negedge clk);
    check_all_zero(0);
    src_q[2].delete();
    exp_b[0].delete();
    req[0] = '0;
    byte_valid[0] = '0;
    ucnt[0] = 0;
    is_tx[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b0;
    exp_g[0].push_back(3'b001);
    exp_g[0].push_back(3'b010);
    load_pkt(0, 0, 2, 8'h31);
    load_pkt(0, 1, 2, 8'h41);
    wait_done(0, 500);

    // Fixed priority: 1 first, then 0 twice, source 2 last.
    exp_g[1].push_back(3'b010);
    load_pkt(1, 1, 4, 8'h61);
    load_pkt(1, 2, 4, 8'h71);
    n = 0;
    while (grant[1] != 3'b010 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("fixed_first_grant", 1, grant[1], 3'b010);
    exp_g[1].push_back(3'b001);
    exp_g[1].push_back(3'b001);
    exp_g[1].push_back(3'b100);
    load_pkt(1, 0, 4, 8'h81);
    load_pkt(1, 0, 4, 8'h91);
    wait_done(1, 3000);

    check("timeout_total", 0, tmo_cnt[0], 1);
    check("timeout_total", 1, tmo_cnt[1], 0);
    check("lost_busy_total", 0, lost_cnt[0], 3);
    check("lost_busy_total", 1, lost_cnt[1], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
